// File: rtl/mux_pkg.sv
// Shared arbitration-mode constants for arb_mux and any future mux variants.
package mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int MODE_SEL   = 2;

endpackage

// File: rtl/rr_pick.sv
// Finds the first asserted request at or after a start index, wrapping around.
module rr_pick #(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    start,
    output logic                gnt_vld,
    output logic [SEL_W-1:0]    gnt_idx
);

    // Walk offsets from farthest to nearest so the nearest request wins last.
    always_comb begin
        int k;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        k       = 0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            k = int'(start) + i;
            if (k >= CHANNELS) begin
                k = k - CHANNELS;
            end
            if (req[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// Registered N-to-1 word multiplexer with valid/ready handshakes and a
// per-instance choice of fixed-priority, round-robin or external selection.
module arb_mux
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    parameter  int MODE     = MODE_RR,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          select,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);

    logic             load_en;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             transfer;

    assign load_en = !out_valid || out_ready;

    generate
        if (MODE == MODE_SEL) begin : g_sel
            // Only the selected channel is eligible; out-of-range selects match nothing.
            always_comb begin
                grant_vld = 1'b0;
                for (int k = 0; k < CHANNELS; k++) begin
                    if (select == SEL_W'(k) && in_valid[k]) begin
                        grant_vld = 1'b1;
                    end
                end
            end
            assign grant_idx = select;
        end else if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] ptr;
            logic             unused_sel;

            assign unused_sel = ^select;

            rr_pick #(.CHANNELS(CHANNELS)) u_pick (
                .req     (in_valid),
                .start   (ptr),
                .gnt_vld (grant_vld),
                .gnt_idx (grant_idx)
            );

            // Pointer moves just past the last winner, only when a word is taken.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ptr <= '0;
                end else if (transfer) begin
                    if (int'(grant_idx) == CHANNELS - 1) begin
                        ptr <= '0;
                    end else begin
                        ptr <= grant_idx + 1'b1;
                    end
                end
            end
        end else begin : g_fixed
            logic unused_sel;

            assign unused_sel = ^select;

            rr_pick #(.CHANNELS(CHANNELS)) u_pick (
                .req     (in_valid),
                .start   ('0),
                .gnt_vld (grant_vld),
                .gnt_idx (grant_idx)
            );
        end
    endgenerate

    always_comb begin
        in_ready = '0;
        if (!reset && load_en && grant_vld) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign transfer = |in_ready;

    // Output register: load on transfer, drain to empty when nothing arrives,
    // hold everything under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load_en) begin
            if (transfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
                out_chan  <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench: three arb_mux instances (fixed, round-robin, select)
// checked by directed vectors and a randomized run against a rule-level model.
module tb_arb_mux;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   in_valid  [3];
    logic [N*W-1:0] in_data   [3];
    logic [N-1:0]   in_ready  [3];
    logic [1:0]     select    [3];
    logic           out_valid [3];
    logic [W-1:0]   out_data  [3];
    logic [1:0]     out_chan  [3];
    logic           out_ready [3];

    bit       m_ov   [3];
    logic [W-1:0] m_data [3];
    int       m_chan [3];
    int       m_ptr  [3];
    int       m_xfer [3];
    bit       m_load [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(W), .CHANNELS(N), .MODE(0)) u_fixed (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .select(select[0]), .out_valid(out_valid[0]),
        .out_data(out_data[0]), .out_chan(out_chan[0]), .out_ready(out_ready[0])
    );

    arb_mux #(.WIDTH(W), .CHANNELS(N), .MODE(1)) u_rr (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .select(select[1]), .out_valid(out_valid[1]),
        .out_data(out_data[1]), .out_chan(out_chan[1]), .out_ready(out_ready[1])
    );

    arb_mux #(.WIDTH(W), .CHANNELS(N), .MODE(2)) u_sel (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_data(in_data[2]),
        .in_ready(in_ready[2]), .select(select[2]), .out_valid(out_valid[2]),
        .out_data(out_data[2]), .out_chan(out_chan[2]), .out_ready(out_ready[2])
    );

    typedef struct {
        int         dut;
        logic [3:0] valid;
        logic [1:0] sel;
        logic       ready;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_chan;
    } vec_t;

    vec_t tbl[10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive the same inputs to all three instances.
    task automatic applyStimulus(input logic [3:0] v, input logic [1:0] s, input logic r, input logic rst);
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = v;
            select[d]    = s;
            out_ready[d] = r;
            in_data[d]   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        end
        reset = rst;
    endtask

    // Winner by the arbitration rules, -1 if none.
    function automatic int pick(input int d);
        int start;
        if (d == 2) begin
            return in_valid[2][select[2]] ? int'(select[2]) : -1;
        end
        start = (d == 1) ? m_ptr[1] : 0;
        for (int i = 0; i < N; i++) begin
            if (in_valid[d][(start + i) % N]) begin
                return (start + i) % N;
            end
        end
        return -1;
    endfunction

    // One clock: compare every instance with the model, then advance the model.
    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            int g;
            logic [3:0] er;
            g         = pick(d);
            m_load[d] = !m_ov[d] || out_ready[d];
            m_xfer[d] = (!reset && m_load[d] && g >= 0) ? g : -1;
            er        = (m_xfer[d] >= 0) ? 4'(1 << g) : 4'b0000;
            checkOutput($sformatf("dut%0d in_ready", d), 32'(in_ready[d]), 32'(er));
            checkOutput($sformatf("dut%0d out_valid", d), 32'(out_valid[d]), 32'(m_ov[d]));
            checkOutput($sformatf("dut%0d out_data", d), out_data[d], m_data[d]);
            checkOutput($sformatf("dut%0d out_chan", d), 32'(out_chan[d]), 32'(m_chan[d]));
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                m_ov[d] = 1'b0; m_data[d] = '0; m_chan[d] = 0; m_ptr[d] = 0;
            end else if (m_load[d]) begin
                if (m_xfer[d] >= 0) begin
                    m_ov[d]   = 1'b1;
                    m_data[d] = in_data[d][m_xfer[d]*W +: W];
                    m_chan[d] = m_xfer[d];
                    m_ptr[d]  = (m_xfer[d] + 1) % N;
                end else begin
                    m_ov[d] = 1'b0;
                end
            end
        end
        #1;
    endtask

    initial begin
        tbl[0] = '{1, 4'b1111, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[1] = '{1, 4'b1111, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[2] = '{1, 4'b1111, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[3] = '{1, 4'b1111, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[4] = '{1, 4'b1111, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[5] = '{0, 4'b1010, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[6] = '{0, 4'b1010, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[7] = '{0, 4'b1010, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[8] = '{2, 4'b1011, 2'd2, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[9] = '{2, 4'b1011, 2'd3, 1'b1, 4'b1000, 1'b1, 2'd3};

        for (int d = 0; d < 3; d++) begin
            m_ov[d] = 1'b0; m_data[d] = '0; m_chan[d] = 0; m_ptr[d] = 0; m_xfer[d] = -1;
        end

        applyStimulus(4'b0000, 2'd0, 1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        applyStimulus(4'b0000, 2'd0, 1'b1, 1'b0);
        #1;
        checkOutput("reset out_valid", 32'(out_valid[1]), 32'd0);
        checkOutput("reset out_data", out_data[1], 32'd0);
        checkOutput("reset out_chan", 32'(out_chan[1]), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready[1]), 32'd0);
        step();

        for (int i = 0; i < 10; i++) begin
            int d;
            d = tbl[i].dut;
            applyStimulus(tbl[i].valid, tbl[i].sel, tbl[i].ready, 1'b0);
            #1;
            checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready[d]), 32'(tbl[i].exp_rdy));
            step();
            checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid[d]), 32'(tbl[i].exp_ov));
            checkOutput($sformatf("vec%0d out_chan", i), 32'(out_chan[d]), 32'(tbl[i].exp_chan));
            checkOutput($sformatf("vec%0d out_data", i), out_data[d], 32'hA0 + 32'(tbl[i].exp_chan));
        end

        // Reset while a word is held and every channel is requesting.
        applyStimulus(4'b1111, 2'd0, 1'b0, 1'b1);
        #1;
        checkOutput("rst in_ready", 32'(in_ready[1]), 32'd0);
        step();
        checkOutput("rst out_valid", 32'(out_valid[1]), 32'd0);
        applyStimulus(4'b1111, 2'd0, 1'b1, 1'b0);
        #1;
        checkOutput("rst restart in_ready", 32'(in_ready[1]), 32'b0001);
        step();
        checkOutput("rst restart chan", 32'(out_chan[1]), 32'd0);
        checkOutput("rst restart data", out_data[1], 32'hA0);

        // Backpressure on the round-robin instance, then a no-bubble replace.
        applyStimulus(4'b0010, 2'd0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput("bp in_ready", 32'(in_ready[1]), 32'd0);
            step();
            checkOutput("bp out_valid", 32'(out_valid[1]), 32'd1);
            checkOutput("bp out_data", out_data[1], 32'hA0);
            checkOutput("bp out_chan", 32'(out_chan[1]), 32'd0);
        end
        applyStimulus(4'b0010, 2'd0, 1'b1, 1'b0);
        #1;
        checkOutput("bp release in_ready", 32'(in_ready[1]), 32'b0010);
        step();
        checkOutput("bp release out_valid", 32'(out_valid[1]), 32'd1);
        checkOutput("bp release out_data", out_data[1], 32'hA1);
        checkOutput("bp release out_chan", 32'(out_chan[1]), 32'd1);

        // Randomized run: producers hold valid and data until their word is taken.
        applyStimulus(4'b0000, 2'd0, 1'b1, 1'b0);
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 3; d++) begin
                for (int k = 0; k < N; k++) begin
                    if (in_valid[d][k] && m_xfer[d] == k) begin
                        in_valid[d][k] = 1'b0;
                    end
                    if (!in_valid[d][k] && $urandom_range(0, 1) == 1) begin
                        in_valid[d][k]          = 1'b1;
                        in_data[d][k*W +: W]    = $urandom;
                    end
                end
                out_ready[d] = ($urandom_range(0, 3) != 0);
                select[d]    = 2'($urandom_range(0, 3));
            end
            reset = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
